// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wer_out
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t              r_state, w_state_next;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opa;
    logic [XLEN:0]       r_rem;
    logic [XLEN-1:0]     r_result;

    // Operand decode at the start cycle
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_sign;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0] w_fast_result;

    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
    assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;
    // Remainder takes the dividend's sign; everything else the xor of both signs
    assign w_sign     = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = funct3[2] && (rs2_val == '0);
    assign w_ovf      = funct3[2] && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
    assign w_fast     = w_div_zero | w_ovf;
    assign w_fast_result = w_div_zero ? (funct3[1] ? rs1_val : '1)
                                      : (funct3[1] ? '0 : MIN_NEG);

    // One iteration step; the low half of r_acc is multiplier (mul) or dividend/quotient (div)
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [XLEN+1:0]   w_rem_sh, w_diff;
    logic              w_ge;
    logic [XLEN:0]     w_rem_step;
    logic [XLEN-1:0]   w_quot_step;
    logic [2*XLEN-1:0] w_acc_step;
    logic [CW-1:0]     w_cnt_dec;

    assign w_sum       = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    assign w_prod_step = {w_sum, r_acc[XLEN-1:1]};
    assign w_rem_sh    = {r_rem, r_acc[XLEN-1]};
    assign w_diff      = w_rem_sh - {2'b00, r_opa};
    assign w_ge        = ~w_diff[XLEN+1];
    assign w_rem_step  = w_ge ? w_diff[XLEN:0] : w_rem_sh[XLEN:0];
    assign w_quot_step = {r_acc[XLEN-2:0], w_ge};
    assign w_acc_step  = r_op[2] ? {r_acc[2*XLEN-1:XLEN], w_quot_step} : w_prod_step;
    assign w_cnt_dec   = r_cnt - 1'b1;

    // Sign fix and result select applied to the values produced by the last step
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_rem_mag, w_quot_fix, w_rem_fix, w_final;

    assign w_prod_fix = r_neg ? -w_prod_step : w_prod_step;
    assign w_quot_fix = r_neg ? -w_quot_step : w_quot_step;
    assign w_rem_mag  = w_rem_step[XLEN-1:0];
    assign w_rem_fix  = r_neg ? -w_rem_mag : w_rem_mag;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot_fix;
            default:                w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_fast ? S_FIN : S_CALC;
            S_CALC:  if (w_cnt_dec == '0) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_FIN);
        wer_out = (r_state == S_FIN) && (r_rd != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_op  <= funct3;
            r_rd  <= rd_in;
            r_neg <= w_sign;
            r_cnt <= CW'(XLEN);
            r_rem <= '0;
            r_acc <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
            r_opa <= funct3[2] ? w_b_mag : w_a_mag;
            if (w_fast) r_result <= w_fast_result;
        end else if (r_state == S_CALC) begin
            r_acc <= w_acc_step;
            r_cnt <= w_cnt_dec;
            if (r_op[2]) r_rem <= w_rem_step;
            if (w_cnt_dec == '0) r_result <= w_final;
        end
    end

    assign result = r_result;
    assign rd_out = r_rd;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file and takes the rv1/rv2 operand values plus the destination index. It computes one result per request and produces a regdata/wer/rd write-back triple that feeds straight back into the register file write port. The core stalls on busy while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request strobe; sampled only when busy=0
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A (register file rv1)
rs2_val  input  XLEN  operand B (register file rv2)
rd_in  input  5  destination register index
busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive
done  output  1  one-cycle pulse when result is valid
result  output  XLEN  write-back data (to register file regdata); held until the next done
rd_out  output  5  destination index latched at start
wer_out  output  1  write-enable pulse = done and (rd_out != 0)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (assert at any time, including mid-operation): state IDLE; busy=0, done=0, wer_out=0, result=0, rd_out=0; any in-flight op is discarded, with no write-back.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 → latch funct3, rd_in, and operands.
  - Signed operands are converted to magnitudes.
  - Latch the result sign: mul = signA xor signB; DIV = signA xor signB; REM = signA.
  - Load counter = XLEN; go to CALC.
- Fast path from IDLE: divide by zero or signed overflow goes directly to FIN with the result preset.
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → rs1_val.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle; the remainder register is XLEN+1 bits wide.
- CALC exit: counter decrements each cycle. At 0, apply the sign fix (two's-complement negate of the 64-bit product, quotient, or remainder as latched), select the output, and go to FIN.
- Result select:
  - MUL = product[31:0].
  - MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- FIN: done=1, wer_out per rule, result/rd_out valid, busy=1 → IDLE next cycle.
- Latency (start edge = cycle 0):
  - Normal op: done high in cycle XLEN+1 (33).
  - Fast path: done high in cycle 1.
- Handshake: start while busy=1 is ignored completely; operands need only be valid in the start cycle.
- Zero operand: no early termination on a zero multiplicand or dividend; full latency applies.
- MULHSU: rs1 is signed, rs2 is unsigned.
- rd_in=0: the op executes, done pulses, and wer_out stays 0.
- Back-to-back: start is accepted in the cycle after FIN (busy=0 again).

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB, done exactly at cycle 33, wer_out=1, rd_out=rd_in=5.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. All done at cycle 1.
- Second start pulsed at cycle 10 of a MUL → ignored; first result is unchanged and only one done pulse occurs. rd_in=0 → done=1, wer_out=0.
- rst_n low at cycle 15 of a DIV → busy/done/result drop to 0 immediately (asynchronous). After release, no done pulse occurs, and a fresh op completes correctly.
